// File: rtl/float_pipe_stage_reg.sv
// Pipeline register stage for floating-point datapath fields.
// The payload fields travel together as one word. With SKID=1 the stage is a
// 2-entry skid buffer whose in_ready comes straight from a flop. With SKID=0
// it is a single entry whose in_ready is combinational. A saturating counter
// records how many cycles the downstream side stalled a valid entry.
module float_pipe_stage_reg #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 28,
  parameter int NF_W   = 23,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_rm,
  input  logic              in_inf_nan,
  input  logic              in_sign,
  input  logic [NF_W-1:0]   in_inf_nan_frac,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W-1:0] in_frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_rm,
  output logic              out_inf_nan,
  output logic              out_sign,
  output logic [NF_W-1:0]   out_inf_nan_frac,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W-1:0] out_frac,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Packed payload layout, MSB first: rm, inf_nan, sign, inf_nan_frac, exp, frac.
  localparam int W = 4 + NF_W + EXP_W + FRAC_W;

  // The encoding equals the number of held entries, so occupancy is the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     main_q, main_d;
  logic [W-1:0]     skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [W-1:0]     in_word;
  logic             out_valid_int;
  logic             in_ready_int;
  logic             in_xfer;
  logic             out_xfer;

  assign in_word       = {in_rm, in_inf_nan, in_sign, in_inf_nan_frac, in_exp, in_frac};
  assign out_valid_int = (state_q != EMPTY);

  generate
    if (SKID != 0) begin : g_skid
      // Registered ready: the upstream path never sees out_ready.
      assign in_ready_int = in_ready_q;
    end else begin : g_single
      // Single entry: accept whenever the slot is free or is draining this cycle.
      assign in_ready_int = !out_valid_int || out_ready;
    end
  endgenerate

  assign in_xfer  = in_valid && in_ready_int;
  assign out_xfer = out_valid_int && out_ready;

  // Next-state and payload steering; flush only discards the valid state.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = in_word;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = in_word;
        end else if (in_xfer) begin
          // Only reachable with SKID=1: downstream stalled, park in the skid slot.
          skid_d  = in_word;
          state_d = TWO;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
    in_ready_d = (state_d != TWO);
  end

  // Stall counter: counts edges where a valid entry is held back; saturates.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_int && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State, payload and counter registers; reset wins over flush and transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready         = in_ready_int;
  assign out_valid        = out_valid_int;
  assign occupancy        = 2'(state_q);
  assign stall_cnt        = stall_cnt_q;
  assign out_frac         = main_q[FRAC_W-1:0];
  assign out_exp          = main_q[FRAC_W +: EXP_W];
  assign out_inf_nan_frac = main_q[FRAC_W+EXP_W +: NF_W];
  assign out_sign         = main_q[W-4];
  assign out_inf_nan      = main_q[W-3];
  assign out_rm           = main_q[W-1:W-2];

endmodule

// File: tb/tb_float_pipe_stage_reg.sv
// Self-checking bench: one SKID=1 stage (CNT_W=4) and one SKID=0 stage share
// the same stimulus; each is compared every cycle against a queue model.
module tb_float_pipe_stage_reg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 28;
  localparam int NF_W   = 23;
  localparam int W      = 4 + NF_W + EXP_W + FRAC_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, flush, in_valid, out_ready;
  logic [W-1:0] in_word;

  // Shared input fields: frac [27:0], exp [35:28], nf [58:36], sign 59, inf_nan 60, rm [62:61].
  logic [1:0]        in_rm;
  logic              in_inf_nan, in_sign;
  logic [NF_W-1:0]   in_nf;
  logic [EXP_W-1:0]  in_exp;
  logic [FRAC_W-1:0] in_frac;
  assign in_frac    = in_word[27:0];
  assign in_exp     = in_word[35:28];
  assign in_nf      = in_word[58:36];
  assign in_sign    = in_word[59];
  assign in_inf_nan = in_word[60];
  assign in_rm      = in_word[62:61];

  logic              a_in_ready, a_out_valid, a_inf_nan, a_sign;
  logic [1:0]        a_rm, a_occ;
  logic [NF_W-1:0]   a_nf;
  logic [EXP_W-1:0]  a_exp;
  logic [FRAC_W-1:0] a_frac;
  logic [3:0]        a_stall;

  logic              b_in_ready, b_out_valid, b_inf_nan, b_sign;
  logic [1:0]        b_rm, b_occ;
  logic [NF_W-1:0]   b_nf;
  logic [EXP_W-1:0]  b_exp;
  logic [FRAC_W-1:0] b_frac;
  logic [15:0]       b_stall;

  float_pipe_stage_reg #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .NF_W(NF_W), .SKID(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_rm(in_rm), .in_inf_nan(in_inf_nan), .in_sign(in_sign),
    .in_inf_nan_frac(in_nf), .in_exp(in_exp), .in_frac(in_frac),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_rm(a_rm), .out_inf_nan(a_inf_nan), .out_sign(a_sign),
    .out_inf_nan_frac(a_nf), .out_exp(a_exp), .out_frac(a_frac),
    .occupancy(a_occ), .stall_cnt(a_stall)
  );

  float_pipe_stage_reg #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .NF_W(NF_W), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_rm(in_rm), .in_inf_nan(in_inf_nan), .in_sign(in_sign),
    .in_inf_nan_frac(in_nf), .in_exp(in_exp), .in_frac(in_frac),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_rm(b_rm), .out_inf_nan(b_inf_nan), .out_sign(b_sign),
    .out_inf_nan_frac(b_nf), .out_exp(b_exp), .out_frac(b_frac),
    .occupancy(b_occ), .stall_cnt(b_stall)
  );

  logic [W-1:0] a_word, b_word;
  assign a_word = {a_rm, a_inf_nan, a_sign, a_nf, a_exp, a_frac};
  assign b_word = {b_rm, b_inf_nan, b_sign, b_nf, b_exp, b_frac};

  // Reference model: FIFO contents, stall counts, and "payload still reset" flags.
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  int unsigned  cnt_a, cnt_b;
  bit           zero_a, zero_b;
  bit           acc_a;
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  // One clock: check both DUTs before the edge, then advance the model at the edge.
  task automatic tick();
    bit ir_a, ir_b;
    @(negedge clk);
    ir_a = (qa.size() < 2);
    ir_b = (qb.size() == 0) || out_ready;
    check_eq("a_occupancy", 64'(a_occ), 64'(qa.size()));
    check_eq("a_out_valid", 64'(a_out_valid), 64'(qa.size() != 0));
    check_eq("a_in_ready", 64'(a_in_ready), 64'(ir_a));
    check_eq("a_stall_cnt", 64'(a_stall), 64'(cnt_a));
    if (qa.size() != 0) check_eq("a_payload", 64'(a_word), 64'(qa[0]));
    else if (zero_a) check_eq("a_payload_reset", 64'(a_word), 64'd0);
    check_eq("b_occupancy", 64'(b_occ), 64'(qb.size()));
    check_eq("b_out_valid", 64'(b_out_valid), 64'(qb.size() != 0));
    check_eq("b_in_ready", 64'(b_in_ready), 64'(ir_b));
    check_eq("b_stall_cnt", 64'(b_stall), 64'(cnt_b));
    if (qb.size() != 0) check_eq("b_payload", 64'(b_word), 64'(qb[0]));
    else if (zero_b) check_eq("b_payload_reset", 64'(b_word), 64'd0);
    @(posedge clk);
    acc_a = in_valid && ir_a && !flush && !rst;
    if (rst) begin
      qa.delete(); qb.delete();
      cnt_a = 0; cnt_b = 0;
      zero_a = 1; zero_b = 1;
    end else begin
      if (qa.size() != 0 && !out_ready && cnt_a < 15) cnt_a++;
      if (qb.size() != 0 && !out_ready && cnt_b < 65535) cnt_b++;
      if (flush) begin
        qa.delete(); qb.delete();
      end else begin
        if (qa.size() != 0 && out_ready) void'(qa.pop_front());
        if (qb.size() != 0 && out_ready) void'(qb.pop_front());
        if (in_valid && ir_a) begin qa.push_back(in_word); zero_a = 0; end
        if (in_valid && ir_b) begin qb.push_back(in_word); zero_b = 0; end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; in_valid = 0;
    tick();
    rst = 0;
  endtask

  initial begin
    logic [W-1:0] seq[3];
    logic [W-1:0] w;
    int idx;

    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_word = '0;
    cnt_a = 0; cnt_b = 0; zero_a = 1; zero_b = 1; acc_a = 0;
    @(posedge clk); #1;
    tick();                       // reset state checked here
    rst = 0;
    tick();

    // Streaming: frac 1..8 on consecutive cycles with out_ready high.
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      w = rand_word();
      w[27:0] = 28'(i);
      in_word = w; in_valid = 1;
      tick();
    end
    in_valid = 0;
    repeat (3) tick();

    // Backpressure: A, B accepted, C held upstream until downstream drains.
    for (int i = 0; i < 3; i++) seq[i] = rand_word();
    idx = 0; out_ready = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 5) out_ready = 1;
      in_valid = (idx < 3);
      in_word  = (idx < 3) ? seq[idx] : '0;
      tick();
      if (acc_a) idx++;
    end
    check_eq("bp_all_accepted", 64'(idx), 64'd3);
    in_valid = 0;

    // Flush colliding with an input transfer while full.
    do_reset();
    out_ready = 0;
    repeat (2) begin in_valid = 1; in_word = rand_word(); tick(); end
    flush = 1; in_valid = 1; in_word = rand_word();
    tick();
    flush = 0; in_valid = 0; out_ready = 1;
    repeat (3) tick();

    // Stall counter saturation on the 4-bit counter.
    do_reset();
    out_ready = 0; in_valid = 1; in_word = rand_word();
    tick();
    in_valid = 0;
    repeat (20) tick();
    check_eq("sat_stall_cnt", 64'(a_stall), 64'd15);
    repeat (2) tick();

    // Reset in the middle of operation with a full buffer.
    do_reset();
    out_ready = 0;
    repeat (2) begin in_valid = 1; in_word = rand_word(); tick(); end
    rst = 1; flush = 0; in_valid = 1; in_word = rand_word();
    tick();
    rst = 0; in_valid = 0;
    repeat (2) tick();

    // Single-entry mode: out_ready toggles while in_valid stays high.
    do_reset();
    in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      out_ready = (i % 2 == 0);
      in_word = rand_word();
      tick();
    end
    in_valid = 0; out_ready = 1;
    repeat (3) tick();

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 40) == 0;
      rst       = ($urandom % 97) == 0;
      in_word   = rand_word();
      tick();
    end
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
